// File: rtl/dcache_pkg.sv
// Data cache shared definitions: address field layout, line geometry,
// controller state encoding and word select/merge helpers.
package dcache_pkg;
  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int TAG_W   = 22;
  localparam int IDX_W   = 5;
  localparam int WRD_W   = 3;
  localparam int OFF_W   = 5;
  localparam int LINE_W  = 256;
  localparam int LINES   = 32;
  localparam int TAG_LSB = 10;
  localparam int IDX_LSB = 5;
  localparam int WRD_LSB = 2;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_WRITEBACK = 2'd1,
    S_ALLOCATE  = 2'd2
  } state_t;

  function automatic logic [DATA_W-1:0] get_word(
    input logic [LINE_W-1:0] line,
    input logic [WRD_W-1:0]  w
  );
    return line[{w, 5'b0} +: DATA_W];
  endfunction

  function automatic logic [LINE_W-1:0] put_word(
    input logic [LINE_W-1:0] line,
    input logic [WRD_W-1:0]  w,
    input logic [DATA_W-1:0] d
  );
    logic [LINE_W-1:0] r;
    r = line;
    r[{w, 5'b0} +: DATA_W] = d;
    return r;
  endfunction
endpackage

// File: rtl/dcache_sram.sv
// Tag/valid/dirty/data storage: one async read port, one write port.
// Ports: clk, rst (clears valid/dirty), rd_idx -> rd_*, we + wr_* write.
module dcache_sram
  import dcache_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic [TAG_W-1:0]  rd_tag,
  output logic [LINE_W-1:0] rd_line,
  output logic              rd_valid,
  output logic              rd_dirty,
  input  logic              we,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [TAG_W-1:0]  wr_tag,
  input  logic [LINE_W-1:0] wr_line,
  input  logic              wr_dirty
);
  logic [TAG_W-1:0]  tag_q  [LINES];
  logic [LINE_W-1:0] data_q [LINES];
  logic [LINES-1:0]  valid_q;
  logic [LINES-1:0]  dirty_q;

  assign rd_tag   = tag_q[rd_idx];
  assign rd_line  = data_q[rd_idx];
  assign rd_valid = valid_q[rd_idx];
  assign rd_dirty = dirty_q[rd_idx];

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (we) begin
      valid_q[wr_idx] <= 1'b1;
      dirty_q[wr_idx] <= wr_dirty;
    end
  end

  // Tag and data arrays carry no reset; valid gates their use.
  always_ff @(posedge clk) begin
    if (we) begin
      tag_q[wr_idx]  <= wr_tag;
      data_q[wr_idx] <= wr_line;
    end
  end
endmodule

// File: rtl/dcache_controller.sv
// Direct-mapped write-back write-allocate data cache controller.
// Ports: CPU side req/wr/addr/wdata -> rdata/stall; memory side mem_*.
module dcache_controller
  import dcache_pkg::*;
#(
  parameter int MEM_LAT_MAX = 1023
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_i,
  input  logic              wr_i,
  input  logic [31:0]       addr_i,
  input  logic [31:0]       wdata_i,
  output logic [31:0]       rdata_o,
  output logic              stall_o,
  output logic              mem_req_o,
  output logic              mem_wr_o,
  output logic [31:0]       mem_addr_o,
  output logic [LINE_W-1:0] mem_wdata_o,
  input  logic [LINE_W-1:0] mem_rdata_i,
  input  logic              mem_ack_i
);
  localparam int UNUSED_LAT = MEM_LAT_MAX;

  logic [TAG_W-1:0]  tag;
  logic [IDX_W-1:0]  idx;
  logic [WRD_W-1:0]  wrd;
  logic [1:0]        unused_byte;

  assign tag         = addr_i[TAG_LSB +: TAG_W];
  assign idx         = addr_i[IDX_LSB +: IDX_W];
  assign wrd         = addr_i[WRD_LSB +: WRD_W];
  assign unused_byte = addr_i[1:0];

  state_t            state;
  logic [TAG_W-1:0]  miss_tag;
  logic [IDX_W-1:0]  miss_idx;

  logic [TAG_W-1:0]  rd_tag;
  logic [LINE_W-1:0] rd_line;
  logic              rd_valid;
  logic              rd_dirty;
  logic              we;
  logic [IDX_W-1:0]  wr_idx;
  logic [TAG_W-1:0]  wr_tag;
  logic [LINE_W-1:0] wr_line;
  logic              wr_dirty;
  logic              hit;
  logic              refill;

  dcache_sram u_sram (
    .clk      (clk_i),
    .rst      (rst_i),
    .rd_idx   (idx),
    .rd_tag   (rd_tag),
    .rd_line  (rd_line),
    .rd_valid (rd_valid),
    .rd_dirty (rd_dirty),
    .we       (we),
    .wr_idx   (wr_idx),
    .wr_tag   (wr_tag),
    .wr_line  (wr_line),
    .wr_dirty (wr_dirty)
  );

  // Hits only count in IDLE so a CPU write never races the refill port.
  assign hit     = (state == S_IDLE) & req_i & rd_valid & (rd_tag == tag);
  assign refill  = (state == S_ALLOCATE) & mem_ack_i;
  assign stall_o = (state != S_IDLE) | (req_i & ~hit);
  assign rdata_o = (hit & ~wr_i) ? get_word(rd_line, wrd) : '0;

  always_comb begin
    we       = 1'b0;
    wr_idx   = idx;
    wr_tag   = tag;
    wr_line  = put_word(rd_line, wrd, wdata_i);
    wr_dirty = 1'b1;
    unique case (1'b1)
      refill: begin
        we       = 1'b1;
        wr_idx   = miss_idx;
        wr_tag   = miss_tag;
        wr_line  = mem_rdata_i;
        wr_dirty = 1'b0;
      end
      (hit & wr_i): begin
        we = 1'b1;
      end
      default: ;
    endcase
  end

  // Miss address is latched so the fill completes even if req_i drops.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= S_IDLE;
      mem_req_o   <= 1'b0;
      mem_wr_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
      miss_tag    <= '0;
      miss_idx    <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (req_i && !hit) begin
            miss_tag  <= tag;
            miss_idx  <= idx;
            mem_req_o <= 1'b1;
            if (rd_valid && rd_dirty) begin
              state       <= S_WRITEBACK;
              mem_wr_o    <= 1'b1;
              mem_addr_o  <= {rd_tag, idx, {OFF_W{1'b0}}};
              mem_wdata_o <= rd_line;
            end else begin
              state      <= S_ALLOCATE;
              mem_wr_o   <= 1'b0;
              mem_addr_o <= {tag, idx, {OFF_W{1'b0}}};
            end
          end
        end
        S_WRITEBACK: begin
          if (mem_ack_i) begin
            state      <= S_ALLOCATE;
            mem_wr_o   <= 1'b0;
            mem_addr_o <= {miss_tag, miss_idx, {OFF_W{1'b0}}};
          end
        end
        S_ALLOCATE: begin
          if (mem_ack_i) begin
            state     <= S_IDLE;
            mem_req_o <= 1'b0;
          end
        end
        default: begin
          state     <= S_IDLE;
          mem_req_o <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: doc/dcache_controller.md
DCACHE_CONTROLLER -- requirements
Module: dcache_controller

Interface
REQ-001 The block SHALL have parameter MEM_LAT_MAX, default 1023: bench-only watchdog bound on cycles waiting for mem_ack_i; it has no functional effect.
REQ-002 The block SHALL have one clock; reset is synchronous and active-high.
REQ-003 clk_i  input  1  clock; all state updates on rising edge.
REQ-004 rst_i  input  1  synchronous active-high reset.
REQ-005 req_i  input  1  CPU data-memory access request (load or store).
REQ-006 wr_i  input  1  1 = store, 0 = load; valid with req_i.
REQ-007 addr_i  input  32  CPU byte address, word-aligned.
REQ-008 wdata_i  input  32  store data.
REQ-009 rdata_o  output  32  load data; valid when req_i=1, wr_i=0, stall_o=0.
REQ-010 stall_o  output  1  CPU pipeline freeze; CPU holds req_i/wr_i/addr_i/wdata_i stable while high.
REQ-011 mem_req_o  output  1  off-chip memory request.
REQ-012 mem_wr_o  output  1  1 = block write-back, 0 = block fetch.
REQ-013 mem_addr_o  output  32  block address, bits [4:0] = 0.
REQ-014 mem_wdata_o  output  256  write-back block data.
REQ-015 mem_rdata_i  input  256  fetched block, valid with mem_ack_i.
REQ-016 mem_ack_i  input  1  one-cycle completion pulse from memory.

Function
REQ-017 Organisation SHALL be direct-mapped, 32 lines x 32 bytes, write-back, write-allocate; fields: tag=addr[31:10], index=addr[9:5], word=addr[4:2].
REQ-018 Hit SHALL be req_i & valid[index] & (tag_store[index]==tag), evaluated combinationally.
REQ-019 Read hit: rdata_o = selected word in the same cycle, stall_o=0; rdata_o SHALL be 0 when there is no read hit.
REQ-020 Write hit: word written and dirty[index] set at the next clock edge, stall_o=0.
REQ-021 Miss (req_i & ~hit) in IDLE: stall_o SHALL be 1 combinationally in that cycle, and SHALL stay 1 until the cycle the access hits.
REQ-022 FSM states: IDLE, WRITEBACK, ALLOCATE; IDLE->WRITEBACK on miss with valid&dirty victim; IDLE->ALLOCATE on miss with clean or invalid victim.
REQ-023 WRITEBACK: mem_req_o=1, mem_wr_o=1, mem_addr_o={victim tag, index, 5'b0}, mem_wdata_o=victim line; on mem_ack_i, go to ALLOCATE.
REQ-024 ALLOCATE: mem_req_o=1, mem_wr_o=0, mem_addr_o={tag, index, 5'b0}; on mem_ack_i, write mem_rdata_i into the line, set valid=1, dirty=0, update tag, go to IDLE.
REQ-025 The retried access SHALL hit in the IDLE cycle after refill (store merges then, setting dirty).
REQ-026 mem_req_o/mem_addr_o/mem_wdata_o SHALL hold stable until mem_ack_i; an ack in the first request cycle is legal; mem_req_o SHALL be 0 in IDLE.
REQ-027 mem_ack_i outside WRITEBACK/ALLOCATE SHALL be ignored.
REQ-028 If req_i drops mid-miss, the transaction in flight SHALL complete and the FSM return to IDLE; no CPU write is performed.
REQ-029 Hit-after-miss minimum penalty: clean miss, ack in first ALLOCATE cycle -> stall_o high exactly 2 cycles.

Reset
REQ-030 rst_i SHALL force state=IDLE and clear all valid and dirty bits, including mid-transaction; mem_req_o=0 from the following cycle.
REQ-031 After reset: mem_req_o=0, mem_wr_o=0, stall_o=req_i, rdata_o=0; tag and data arrays are not reset.

Structure
REQ-032 Package dcache_pkg SHALL hold the field widths/positions (TAG_W=22, IDX_W=5, LINE_W=256), line count, and the state encoding.
REQ-033 Tag/valid/dirty/data storage SHALL be one sub-module dcache_sram (single write port, async read); the FSM and hit logic stay in dcache_controller.

Verification
REQ-034 Cold load addr 0x0000_0040, ack 3 cycles after req -> mem_addr_o=0x40, mem_wr_o=0, then rdata_o = word 0 of mem_rdata_i, stall_o low.
REQ-035 Store 0xDEADBEEF to 0x44 after REQ-034 -> no stall, no mem_req_o; load 0x44 -> 0xDEADBEEF.
REQ-036 Load 0x0000_0444 (same index, new tag) -> WRITEBACK with mem_addr_o=0x40 and line containing 0xDEADBEEF, then ALLOCATE with mem_addr_o=0x440.
REQ-037 rst_i asserted during ALLOCATE -> mem_req_o=0 next cycle; load 0x44 then misses.
REQ-038 Clean miss with ack in the first ALLOCATE cycle -> stall_o high exactly 2 cycles; spurious mem_ack_i in IDLE -> no state change.
